player_hp_controller: RTL and testbench
=======================================

Name: player_hp_controller

Overview:
- Downstream consumer of the player position block.
- Takes the registered player rectangle (pos/w/h) and a stream of attack rectangles from the attack engine, and detects overlap against an inset hitbox.
- Applies at most one damage event per frame, with invincibility frames and a Sans-style karma (KR) drain.
- Feeds the HP bar renderer and game-over logic.

Parameters:
- MAX_HP, 92, HP at reset/restart (fits 7 bits).
- HITBOX_INSET, 4, pixels trimmed from each player edge before overlap test.
- INVINCIBLE_FRAMES, 2, frame_ticks of immunity after a hit.
- KR_PER_HIT, 3, karma added per applied hit.
- KR_MAX, 40, karma ceiling.
- KR_DRAIN_FRAMES, 30, frame_ticks between karma drain steps.

Ports:
- clk_player_control  in  1  system clock
- reset_n  in  1  async active-low reset
- game_restart  in  1  sync pulse, same effect as reset
- frame_tick  in  1  one-cycle pulse per video frame
- player_pos_x, player_pos_y, player_w, player_h  in  10 each  player rectangle
- atk_valid  in  1  attack descriptor valid
- atk_ready  out  1  descriptor accepted when valid&ready
- atk_x0, atk_y0, atk_x1, atk_y1  in  10 each  attack box, x1/y1 exclusive
- atk_damage  in  4  damage of this attack
- player_hp  out  7  current HP
- player_kr  out  7  current karma
- hit_flash  out  1  high while invincible
- player_dead  out  1  HP reached 0

Behaviour:
Reset (async on reset_n low, or sync on game_restart):
- player_hp=MAX_HP; player_kr=0; hit_flash=0; player_dead=0; atk_ready=1; state=ALIVE.
- Internal: pending_dmg=0, iframe_cnt=0, drain_cnt=0, pipeline valid cleared.
- An in-flight descriptor at reset is discarded.

Hitbox:
- hx0=pos_x+INSET, hx1=pos_x+w-INSET; same for y.
- Computed in 11 bits, no wrap.
- If w or h <= 2*INSET, the hitbox is empty and never hits.

Overlap:
- hit = (hx0<atk_x1)&(atk_x0<hx1)&(hy0<atk_y1)&(atk_y0<hy1).
- Touching edges do not hit.
- Descriptors with x0>=x1 or y0>=y1 never hit.

Pipeline (latency 1):
- Accepted descriptor at cycle t is compared and registered at t+1.
- At t+1, if hit: pending_dmg = max(pending_dmg, atk_damage).
- A descriptor accepted in the same cycle as frame_tick counts toward the next frame.

atk_ready:
- 1 in ALIVE and HURT, 0 in DEAD.
- No backpressure otherwise; one descriptor per cycle.

Frame processing on frame_tick (pending_dmg then cleared):
- ALIVE with pending_dmg>0:
  - hp = hp - dmg, saturating at 0.
  - kr = min(kr+KR_PER_HIT, KR_MAX, new_hp-1), floor 0.
  - iframe_cnt = INVINCIBLE_FRAMES; go to HURT.
  - If new hp=0: go to DEAD instead.
- HURT: pending damage is ignored; iframe_cnt decrements; return to ALIVE when it reaches 0.
- DEAD: absorbing until reset or game_restart; all counters frozen; player_dead=1.

Karma drain (ALIVE and HURT):
- drain_cnt counts frame_ticks and wraps at KR_DRAIN_FRAMES.
- On wrap, if kr>0 and hp>1: hp-=1, kr-=1.
- Drain never kills (hp stays >=1).
- Drain and a hit on the same tick: damage is applied first, then drain is evaluated on the result.

Invariants:
- kr <= hp-1 whenever hp>0.
- hit_flash = (state==HURT).
- All outputs are registered.

Optional Feature:
- Macro: PLAYER_HP_KARMA_EN.
- Defined: karma accumulation and drain as above.
- Undefined: player_kr is tied to 0, drain_cnt logic is removed, and hits subtract damage only.

Decomposition:
- Shared package player_hp_pkg holds:
  - state encoding (ALIVE=0, HURT=1, DEAD=2, 2 bits);
  - HP/KR width (7);
  - coordinate width (10);
  - damage width (4).
- One sub-module: player_hitbox_overlap (combinational inset + AABB test, 11-bit arithmetic), instantiated once before the stage-1 register.

Test Plan:
- Reset / hit / expiry: reset_n low -> hp=92, kr=0, dead=0. Player (100,100,30,30); atk (120,120)-(140,140) dmg 5, then frame_tick -> hp=87, kr=3, hit_flash=1. After 2 ticks, hit_flash=0.
- Edge touch: atk x0=126 with inset hitbox hx1=126 -> no damage. Same attack with x0=125 -> damage applied.
- Multiple hits in one frame: dmg 2, 7, 4 all overlapping within one frame -> single hit, hp drops by 7.
- Hit during invincibility: second overlapping attack while in HURT -> hp unchanged, pending cleared.
- Karma drain: hp=10, kr=9, 30 frame_ticks with no hits -> hp=9, kr=8. With hp=1, kr=0, drain -> hp stays 1.
- Death and restart: dmg 15 with hp=12 -> hp=0, player_dead=1, atk_ready=0. game_restart -> hp=92. Also: reset_n asserted mid-pipeline -> pending discarded, no post-reset damage.

Source files
------------

// File: rtl/player_hp_pkg.sv
// Shared widths, tuning constants, state encoding and helpers for the player HP controller.
// Karma accumulation/drain is compiled in only when PLAYER_HP_KARMA_EN is defined.
package player_hp_pkg;

  localparam int unsigned HP_W              = 7;
  localparam int unsigned COORD_W           = 10;
  localparam int unsigned DMG_W             = 4;
  localparam int unsigned HB_W              = COORD_W + 1;

  localparam int unsigned MAX_HP            = 92;
  localparam int unsigned HITBOX_INSET      = 4;
  localparam int unsigned INVINCIBLE_FRAMES = 2;
  localparam int unsigned KR_PER_HIT        = 3;
  localparam int unsigned KR_MAX            = 40;
  localparam int unsigned KR_DRAIN_FRAMES   = 30;

  localparam int unsigned IFR_W             = $clog2(INVINCIBLE_FRAMES + 1);
  localparam int unsigned DRAIN_W           = $clog2(KR_DRAIN_FRAMES);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HURT  = 2'd1,
    DEAD  = 2'd2
  } hp_state_e;

  // Stage-1 record of one accepted attack descriptor.
  typedef struct packed {
    logic             vld;
    logic             hit;
    logic [DMG_W-1:0] dmg;
  } s1_t;

  // Karma after a hit: add, clamp to ceiling, then keep it strictly below the new HP.
  function automatic logic [HP_W-1:0] kr_after_hit(input logic [HP_W-1:0] kr,
                                                   input logic [HP_W-1:0] new_hp);
    logic [HP_W:0]   sum;
    logic [HP_W-1:0] res;
    sum = (HP_W+1)'(kr) + (HP_W+1)'(KR_PER_HIT);
    res = (sum > (HP_W+1)'(KR_MAX)) ? HP_W'(KR_MAX) : HP_W'(sum);
    if (new_hp == '0) begin
      res = '0;
    end else if (res > (new_hp - HP_W'(1))) begin
      res = new_hp - HP_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/player_hitbox_overlap.sv
// Combinational inset-hitbox vs. attack-box overlap test in 11-bit arithmetic.
module player_hitbox_overlap
  import player_hp_pkg::*;
(
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] atk_x0,
  input  logic [COORD_W-1:0] atk_y0,
  input  logic [COORD_W-1:0] atk_x1,
  input  logic [COORD_W-1:0] atk_y1,
  output logic               hit_c
);

  logic [HB_W-1:0] hx0, hx1, hy0, hy1;
  logic            box_ok;
  logic            ovl_x, ovl_y;

  always_comb begin
    hx0 = HB_W'(pos_x) + HB_W'(HITBOX_INSET);
    hx1 = HB_W'(pos_x) + HB_W'(w) - HB_W'(HITBOX_INSET);
    hy0 = HB_W'(pos_y) + HB_W'(HITBOX_INSET);
    hy1 = HB_W'(pos_y) + HB_W'(h) - HB_W'(HITBOX_INSET);

    // Collapsed hitboxes and inverted descriptors are rejected before the edge tests.
    box_ok = (w > COORD_W'(2 * HITBOX_INSET)) && (h > COORD_W'(2 * HITBOX_INSET)) &&
             (atk_x0 < atk_x1) && (atk_y0 < atk_y1);

    ovl_x = (hx0 < HB_W'(atk_x1)) && (HB_W'(atk_x0) < hx1);
    ovl_y = (hy0 < HB_W'(atk_y1)) && (HB_W'(atk_y0) < hy1);
    hit_c = box_ok && ovl_x && ovl_y;
  end

endmodule

// File: rtl/player_hp_controller.sv
// Player HP/karma controller: attack overlap pipeline, per-frame damage, i-frames, karma drain.
// Optional karma behaviour is enabled with PLAYER_HP_KARMA_EN.
module player_hp_controller
  import player_hp_pkg::*;
(
  input  logic               clk_player_control,
  input  logic               reset_n,
  input  logic               game_restart,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] player_pos_x,
  input  logic [COORD_W-1:0] player_pos_y,
  input  logic [COORD_W-1:0] player_w,
  input  logic [COORD_W-1:0] player_h,
  input  logic               atk_valid,
  output logic               atk_ready,
  input  logic [COORD_W-1:0] atk_x0,
  input  logic [COORD_W-1:0] atk_y0,
  input  logic [COORD_W-1:0] atk_x1,
  input  logic [COORD_W-1:0] atk_y1,
  input  logic [DMG_W-1:0]   atk_damage,
  output logic [HP_W-1:0]    player_hp,
  output logic [HP_W-1:0]    player_kr,
  output logic               hit_flash,
  output logic               player_dead
);

  hp_state_e         state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [DMG_W-1:0]  pend_q, pend_d;
  logic [DMG_W-1:0]  pend_eff;
  logic [IFR_W-1:0]  iframe_q, iframe_d;
  s1_t               s1_q, s1_d;
  logic              ready_q, ready_d;
  logic              flash_q, flash_d;
  logic              dead_q, dead_d;
  logic              ovl_hit_c;
`ifdef PLAYER_HP_KARMA_EN
  logic [HP_W-1:0]    kr_q, kr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
`endif

  player_hitbox_overlap u_overlap (
    .pos_x  (player_pos_x),
    .pos_y  (player_pos_y),
    .w      (player_w),
    .h      (player_h),
    .atk_x0 (atk_x0),
    .atk_y0 (atk_y0),
    .atk_x1 (atk_x1),
    .atk_y1 (atk_y1),
    .hit_c  (ovl_hit_c)
  );

  always_comb begin
    s1_d     = '0;
    s1_d.vld = atk_valid && ready_q;
    s1_d.hit = atk_valid && ready_q && ovl_hit_c;
    s1_d.dmg = s1_d.hit ? atk_damage : '0;

    // The stage-1 entry was accepted before this cycle, so it belongs to the current frame.
    pend_eff = pend_q;
    if (s1_q.vld && s1_q.hit && (s1_q.dmg > pend_q)) begin
      pend_eff = s1_q.dmg;
    end

    state_d  = state_q;
    hp_d     = hp_q;
    pend_d   = pend_eff;
    iframe_d = iframe_q;
`ifdef PLAYER_HP_KARMA_EN
    kr_d     = kr_q;
    drain_d  = drain_q;
`endif

    if (frame_tick) begin
      pend_d = '0;
      unique case (state_q)
        ALIVE: begin
          if (pend_eff != '0) begin
            hp_d = (hp_q > HP_W'(pend_eff)) ? (hp_q - HP_W'(pend_eff)) : '0;
`ifdef PLAYER_HP_KARMA_EN
            kr_d = kr_after_hit(kr_q, hp_d);
`endif
            if (hp_d == '0) begin
              state_d = DEAD;
            end else begin
              state_d  = HURT;
              iframe_d = IFR_W'(INVINCIBLE_FRAMES);
            end
          end
        end
        HURT: begin
          iframe_d = (iframe_q > IFR_W'(1)) ? (iframe_q - IFR_W'(1)) : '0;
          if (iframe_q <= IFR_W'(1)) begin
            state_d = ALIVE;
          end
        end
        default: begin
        end
      endcase

`ifdef PLAYER_HP_KARMA_EN
      // Drain looks at the post-damage values; the hp>1 guard keeps it from killing.
      if (state_q != DEAD) begin
        if (drain_q == DRAIN_W'(KR_DRAIN_FRAMES - 1)) begin
          drain_d = '0;
          if ((kr_d != '0) && (hp_d > HP_W'(1))) begin
            hp_d = hp_d - HP_W'(1);
            kr_d = kr_d - HP_W'(1);
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
`endif
    end

    if (game_restart) begin
      state_d  = ALIVE;
      hp_d     = HP_W'(MAX_HP);
      pend_d   = '0;
      iframe_d = '0;
      s1_d     = '0;
`ifdef PLAYER_HP_KARMA_EN
      kr_d     = '0;
      drain_d  = '0;
`endif
    end

    ready_d = (state_d != DEAD);
    flash_d = (state_d == HURT);
    dead_d  = (state_d == DEAD);
  end

  always_ff @(posedge clk_player_control or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ALIVE;
      hp_q     <= HP_W'(MAX_HP);
      pend_q   <= '0;
      iframe_q <= '0;
      s1_q     <= '0;
      ready_q  <= 1'b1;
      flash_q  <= 1'b0;
      dead_q   <= 1'b0;
`ifdef PLAYER_HP_KARMA_EN
      kr_q     <= '0;
      drain_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      pend_q   <= pend_d;
      iframe_q <= iframe_d;
      s1_q     <= s1_d;
      ready_q  <= ready_d;
      flash_q  <= flash_d;
      dead_q   <= dead_d;
`ifdef PLAYER_HP_KARMA_EN
      kr_q     <= kr_d;
      drain_q  <= drain_d;
`endif
    end
  end

  assign atk_ready   = ready_q;
  assign player_hp   = hp_q;
  assign hit_flash   = flash_q;
  assign player_dead = dead_q;
`ifdef PLAYER_HP_KARMA_EN
  assign player_kr   = kr_q;
`else
  assign player_kr   = '0;
`endif

endmodule

// File: tb/tb_player_hp_controller.sv
// Bench for player_hp_controller: directed vector table, corner sequences, random vs. reference model.
module tb_player_hp_controller;

`ifdef PLAYER_HP_KARMA_EN
  localparam bit KARMA = 1'b1;
`else
  localparam bit KARMA = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       game_restart;
  logic       frame_tick;
  logic [9:0] player_pos_x, player_pos_y, player_w, player_h;
  logic       atk_valid;
  logic       atk_ready;
  logic [9:0] atk_x0, atk_y0, atk_x1, atk_y1;
  logic [3:0] atk_damage;
  logic [6:0] player_hp, player_kr;
  logic       hit_flash, player_dead;

  int errors = 0;
  int checks = 0;

  player_hp_controller dut (
    .clk_player_control (clk),
    .reset_n            (reset_n),
    .game_restart       (game_restart),
    .frame_tick         (frame_tick),
    .player_pos_x       (player_pos_x),
    .player_pos_y       (player_pos_y),
    .player_w           (player_w),
    .player_h           (player_h),
    .atk_valid          (atk_valid),
    .atk_ready          (atk_ready),
    .atk_x0             (atk_x0),
    .atk_y0             (atk_y0),
    .atk_x1             (atk_x1),
    .atk_y1             (atk_y1),
    .atk_damage         (atk_damage),
    .player_hp          (player_hp),
    .player_kr          (player_kr),
    .hit_flash          (hit_flash),
    .player_dead        (player_dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    bit vld;
    int x0, y0, x1, y1, dmg;
    int w;
    int hp, kr;
    bit fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit tick, bit vld, int x0, int y0, int x1, int y1, int dmg,
                             int w, int hp, int kr, bit fl);
    vec_t r;
    r.tick = tick; r.vld = vld; r.x0 = x0; r.y0 = y0; r.x1 = x1; r.y1 = y1;
    r.dmg = dmg; r.w = w; r.hp = hp; r.kr = kr; r.fl = fl;
    return r;
  endfunction

  // Reference model: game rules in plain integers.
  int m_hp, m_kr, m_ifr, m_pend, m_prev, m_ticks;
  bit m_dead;

  task automatic model_reset();
    m_hp = 92; m_kr = 0; m_ifr = 0; m_pend = 0; m_prev = 0; m_ticks = 0; m_dead = 1'b0;
  endtask

  function automatic bit model_hit(int px, int py, int w, int h, int x0, int y0, int x1, int y1);
    if (w <= 8 || h <= 8 || x0 >= x1 || y0 >= y1) return 1'b0;
    return (px + 4 < x1) && (x0 < px + w - 4) && (py + 4 < y1) && (y0 < py + h - 4);
  endfunction

  task automatic model_step(bit rst, bit tick, int new_prev);
    int eff;
    if (rst) begin
      model_reset();
      return;
    end
    eff = (m_pend > m_prev) ? m_pend : m_prev;
    if (tick && !m_dead) begin
      if (m_ifr > 0) begin
        m_ifr--;
      end else if (eff > 0) begin
        m_hp = (m_hp > eff) ? m_hp - eff : 0;
        if (KARMA) begin
          m_kr = m_kr + 3;
          if (m_kr > 40) m_kr = 40;
          if (m_kr > m_hp - 1) m_kr = m_hp - 1;
          if (m_kr < 0) m_kr = 0;
        end
        if (m_hp == 0) m_dead = 1'b1;
        else m_ifr = 2;
      end
      m_ticks++;
      if (KARMA && (m_ticks % 30 == 0) && m_kr > 0 && m_hp > 1) begin
        m_hp--;
        m_kr--;
      end
    end
    m_pend = tick ? 0 : eff;
    m_prev = new_prev;
  endtask

  task automatic drive(bit rst, bit tick, bit vld, int px, int py, int w, int h,
                       int x0, int y0, int x1, int y1, int dmg);
    game_restart = rst;
    frame_tick   = tick;
    atk_valid    = vld;
    player_pos_x = 10'(px); player_pos_y = 10'(py);
    player_w     = 10'(w);  player_h     = 10'(h);
    atk_x0 = 10'(x0); atk_y0 = 10'(y0); atk_x1 = 10'(x1); atk_y1 = 10'(y1);
    atk_damage   = 4'(dmg);
  endtask

  task automatic idle(bit tick);
    drive(1'b0, tick, 1'b0, 100, 100, 30, 30, 0, 0, 0, 0, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, int ehp, int ekr, bit efl, bit edead, bit erdy);
    checks++;
    if (player_hp !== 7'(ehp) || player_kr !== 7'(ekr) || hit_flash !== efl ||
        player_dead !== edead || atk_ready !== erdy) begin
      errors++;
      $display("FAIL %s: got hp=%0d kr=%0d flash=%0b dead=%0b ready=%0b, want hp=%0d kr=%0d flash=%0b dead=%0b ready=%0b",
               nm, player_hp, player_kr, hit_flash, player_dead, atk_ready,
               ehp, ekr, efl, edead, erdy);
    end
  endtask

  function automatic int kv(int k);
    return KARMA ? k : 0;
  endfunction

  function automatic int clampc(int x);
    if (x < 0) return 0;
    if (x > 1023) return 1023;
    return x;
  endfunction

  initial begin
    vec_t t;
    int px, py, pw, ph, x0, y0, x1, y1, dmg, nprev;
    bit rst, tick, vld;

    // Player at (100,100) 30x30 -> inset hitbox [104,126) in both axes.
    vecs.push_back(v(0, 0,   0,   0,   0,   0, 0, 30, 92,  0, 0));
    vecs.push_back(v(0, 1, 120, 120, 140, 140, 5, 30, 92,  0, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 87,  3, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 87,  3, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 87,  3, 0));
    vecs.push_back(v(0, 1, 126, 110, 140, 120, 9, 30, 87,  3, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 87,  3, 0));
    vecs.push_back(v(0, 1, 125, 110, 140, 120, 9, 30, 87,  3, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 78,  6, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 78,  6, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 78,  6, 0));
    vecs.push_back(v(0, 1, 120, 120, 140, 140, 5, 30, 78,  6, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 73,  9, 1));
    vecs.push_back(v(0, 1, 120, 120, 140, 140, 9, 30, 73,  9, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 73,  9, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 73,  9, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 73,  9, 0));
    vecs.push_back(v(0, 1, 120, 120, 140, 140, 2, 30, 73,  9, 0));
    vecs.push_back(v(0, 1, 120, 120, 140, 140, 7, 30, 73,  9, 0));
    vecs.push_back(v(0, 1, 120, 120, 140, 140, 4, 30, 73,  9, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 66, 12, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 66, 12, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 66, 12, 0));
    vecs.push_back(v(1, 1, 120, 120, 140, 140, 3, 30, 66, 12, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 63, 15, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 63, 15, 1));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 63, 15, 0));
    vecs.push_back(v(0, 1, 100, 100, 140, 140, 9,  8, 63, 15, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 63, 15, 0));
    vecs.push_back(v(0, 1, 124, 120, 110, 140, 9, 30, 63, 15, 0));
    vecs.push_back(v(1, 0,   0,   0,   0,   0, 0, 30, 63, 15, 0));

    reset_n = 1'b0;
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", 92, 0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(1'b0, t.tick, t.vld, 100, 100, t.w, 30, t.x0, t.y0, t.x1, t.y1, t.dmg);
      cycle();
      check($sformatf("vec%0d", i), t.hp, kv(t.kr), t.fl, 1'b0, 1'b1);
    end

    // Karma drain after exactly 30 frame ticks from restart.
    drive(1'b1, 1'b0, 1'b0, 100, 100, 30, 30, 0, 0, 0, 0, 0);
    cycle();
    check("restart", 92, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 100, 100, 30, 30, 120, 120, 140, 140, 5);
    cycle();
    idle(1'b1);
    cycle();
    check("drain_hit", 87, kv(3), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 28; i++) begin
      idle(1'b1);
      cycle();
    end
    check("drain_pre", 87, kv(3), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    cycle();
    check("drain_wrap", KARMA ? 86 : 87, kv(2), 1'b0, 1'b0, 1'b1);

    // Death, descriptors refused while dead, then restart.
    drive(1'b1, 1'b0, 1'b0, 100, 100, 30, 30, 0, 0, 0, 0, 0);
    cycle();
    for (int f = 0; f < 20 && player_dead !== 1'b1; f++) begin
      drive(1'b0, 1'b0, 1'b1, 100, 100, 30, 30, 120, 120, 140, 140, 15);
      cycle();
      for (int k = 0; k < 3; k++) begin
        idle(1'b1);
        cycle();
      end
    end
    check("death", 0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 100, 100, 30, 30, 120, 120, 140, 140, 15);
    cycle();
    idle(1'b1);
    cycle();
    check("dead_frozen", 0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 100, 100, 30, 30, 0, 0, 0, 0, 0);
    cycle();
    check("restart_after_death", 92, 0, 1'b0, 1'b0, 1'b1);

    // Async reset with a hit sitting in the pipeline: it must be dropped.
    drive(1'b0, 1'b0, 1'b1, 100, 100, 30, 30, 120, 120, 140, 140, 9);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    idle(1'b0);
    #1;
    check("async_reset", 92, 0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    cycle();
    idle(1'b1);
    cycle();
    check("post_reset_tick", 92, 0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the reference model.
    drive(1'b1, 1'b0, 1'b0, 100, 100, 30, 30, 0, 0, 0, 0, 0);
    cycle();
    model_reset();
    px = 100; py = 100; pw = 30; ph = 30;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        px = int'($urandom_range(0, 900));
        py = int'($urandom_range(0, 900));
        pw = int'($urandom_range(0, 60));
        ph = int'($urandom_range(0, 60));
      end
      rst  = ($urandom_range(0, 149) == 0);
      tick = ($urandom_range(0, 3) == 0);
      vld  = ($urandom_range(0, 2) == 0);
      x0   = clampc(px + int'($urandom_range(0, 90)) - 30);
      y0   = clampc(py + int'($urandom_range(0, 90)) - 30);
      x1   = clampc(x0 + int'($urandom_range(0, 25)) - 2);
      y1   = clampc(y0 + int'($urandom_range(0, 25)) - 2);
      dmg  = int'($urandom_range(0, 15));
      nprev = (vld && !m_dead && model_hit(px, py, pw, ph, x0, y0, x1, y1)) ? dmg : 0;
      drive(rst, tick, vld, px, py, pw, ph, x0, y0, x1, y1, dmg);
      cycle();
      model_step(rst, tick, nprev);
      check($sformatf("rand%0d", c), m_hp, m_kr, (m_ifr > 0) && !m_dead, m_dead, !m_dead);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
